serial_addsub: RTL
==================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter N, default 4096, operand width in bits.
REQ-002 SHALL have parameter BLOCK, default 128, bits processed per cycle; NB = N/BLOCK is derived locally.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, operand request.
REQ-006 SHALL have port in_ready, output, 1, block can accept an operand request.
REQ-007 SHALL have port a, input, N, unsigned operand A.
REQ-008 SHALL have port b, input, N, unsigned operand B.
REQ-009 SHALL have port cin, input, 1, carry-in for add or borrow-in for subtract.
REQ-010 SHALL have port mode, input, 1, 1 = add, 0 = subtract.
REQ-011 SHALL have port flush, input, 1, synchronous abort of the operation in flight.
REQ-012 SHALL have port out_valid, output, 1, result available.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-014 SHALL have port sum, output, N, result modulo 2^N.
REQ-015 SHALL have port cout, output, 1, carry-out (add) or borrow-out (subtract).
REQ-016 SHALL have port zero, output, 1, sum == 0.

Function
REQ-017 SHALL implement a three-state FSM:
- IDLE: in_ready=1.
- RUN: one BLOCK slice per cycle.
- DONE: out_valid=1.
REQ-018 SHALL accept a request on the rising edge where in_valid && in_ready, registering a, b, cin and mode, clearing the block counter and entering RUN.
REQ-019 SHALL ignore a, b, cin and mode at all times other than the accept edge.
REQ-020 In RUN, each cycle SHALL compute slice k (bits k*BLOCK+:BLOCK) using the chained carry/borrow register, seeded with the latched cin for k=0, and write the slice into the result register.
REQ-021 SHALL define add as {cout,sum} = A+B+cin.
REQ-022 SHALL define subtract as sum = (A-B-cin) mod 2^N, with cout=1 exactly when A < B+cin.
REQ-023 SHALL leave RUN after slice NB-1, so that out_valid rises exactly NB cycles after the accept edge.
REQ-024 In DONE, sum, cout and zero SHALL remain stable until the edge where out_valid && out_ready, then return to IDLE.
REQ-025 In_ready SHALL be 0 in RUN and DONE; no new request is accepted in the cycle the result is consumed, giving a minimum initiation interval of NB+2 cycles.
REQ-026 Zero SHALL be computed from the completed result and valid only while out_valid=1.
REQ-027 Flush=1 SHALL return the FSM to IDLE on the next edge from any state, deassert out_valid, and drop the operation with no result produced.
REQ-028 Flush SHALL take priority over accept and over out_ready.
REQ-029 While the FSM stays in DONE, out_ready=0 SHALL hold the result indefinitely with no loss.
REQ-030 SHALL require N % BLOCK == 0 and NB >= 2; violating either SHALL stop elaboration.
REQ-031 The counter width SHALL be clog2(NB) bits; the counter SHALL not wrap within one operation.

Reset
REQ-032 Reset assertion SHALL asynchronously force:
- FSM to IDLE, counter and carry register to 0;
- outputs in_ready=1, out_valid=0, sum=0, cout=0, zero=0.
REQ-033 Reset mid-operation SHALL discard the operation; after release the block accepts a new request in the first cycle.

Verification (N=256, BLOCK=64)
REQ-034 Add with carry chain:
- Stimulus: A = 2^256-1, B=0, cin=1, mode=1.
- Response: sum=0, cout=1, zero=1; out_valid rises exactly 4 cycles after accept.
REQ-035 Subtract with borrow:
- Stimulus: A=5, B=7, cin=0, mode=0.
- Response: sum=2^256-2, cout=1, zero=0.
REQ-036 Backpressure:
- Stimulus: A=3, B=4, mode=1; hold out_ready=0 for 10 cycles.
- Response: sum=7 stable, out_valid=1 throughout, in_ready=0; returns to IDLE on the out_ready edge.
REQ-037 Flush mid-RUN:
- Stimulus: assert flush on cycle 2 after accept.
- Response: out_valid never rises; in_ready=1 on the next cycle; a subsequent request A=1, B=1, mode=0 yields sum=0, cout=0, zero=1.
REQ-038 Reset mid-RUN:
- Stimulus: assert rst_n=0 on cycle 2 after accept.
- Response: all outputs take reset values immediately; after release a request A=2^128, B=2^128, mode=1 yields sum=2^129, cout=0.
REQ-039 Random regression:
- Stimulus: 1000 random A, B, cin, mode with random out_ready stalls.
- Response: results match a reference model bit-exactly; every request produces exactly one result.

Source files
------------

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: one BLOCK-bit slice per cycle with a chained carry/borrow.
// Operands shift right each cycle and the result shifts in from the top, so no wide indexed muxes are needed.
module serial_addsub #(
  parameter int N     = 4096,
  parameter int BLOCK = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         mode,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         zero
);
  localparam int NB = N / BLOCK;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  generate
    if ((N % BLOCK) != 0 || NB < 2) begin : g_bad_cfg
      $error("serial_addsub: N must be a multiple of BLOCK with N/BLOCK >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_r, b_r, sum_r;
  logic           mode_r, carry;
  logic [CW-1:0]  cnt;
  logic [BLOCK:0] slice;
  logic           accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_nxt = RUN;
        RUN:     if (cnt == LAST) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Top bit of the BLOCK+1 result is carry-out on add and borrow-out (negative) on subtract.
  always_comb begin
    slice = '0;
    if (mode_r)
      slice = {1'b0, a_r[BLOCK-1:0]} + {1'b0, b_r[BLOCK-1:0]} + {{BLOCK{1'b0}}, carry};
    else
      slice = {1'b0, a_r[BLOCK-1:0]} - {1'b0, b_r[BLOCK-1:0]} - {{BLOCK{1'b0}}, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      mode_r <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_r    <= a;
      b_r    <= b;
      mode_r <= mode;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == RUN && !flush) begin
      a_r   <= a_r >> BLOCK;
      b_r   <= b_r >> BLOCK;
      sum_r <= {slice[BLOCK-1:0], sum_r[N-1:BLOCK]};
      carry <= slice[BLOCK];
      if (cnt != LAST) cnt <= cnt + CW'(1);
    end
  end

  assign sum  = sum_r;
  assign cout = carry;
  assign zero = out_valid && (sum_r == '0);
endmodule
